wr_port_arb: RTL and testbench

WR_PORT_ARB -- requirements
Module: wr_port_arb

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/wr_port_arb.sv | 83 ++++++++
 tb/tb_wr_port_arb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default widths and Gray/binary pointer conversion.
// Functions work on a 32-bit container; callers zero-extend narrower
// pointers on the way in and truncate the result on the way out.
package fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 6;
    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam int CODE_W = 32;
    typedef logic [CODE_W-1:0] code_t;

    // Binary to reflected Gray code.
    function automatic code_t bin2gray(input code_t b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code back to binary (prefix XOR from the MSB down).
    function automatic code_t gray2bin(input code_t g);
        code_t b;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational; only the
// identity of the last winner is stored, and it moves only when a grant
// is actually issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 = requester 1 won the most recent grant, so requester 0 wins a tie.
    logic last_q;

    // Pick a winner: a lone requester wins, a tie goes to whoever did not win last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise any path that skips an assignment infers a latch.
        gnt = 2'b00;
        if (advance) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Remember the last winner; reset favours requester 0 on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/wr_port_arb.sv
// Write port of an async FIFO shared by two requesters. Arbitrates the
// writers, drives the RAM write port, and keeps the binary/Gray write
// pointer plus registered full and almost_full flags.
module wr_port_arb
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int AF_MARGIN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [ADDR_WIDTH:0]   rptr_gray_s,
    output logic [1:0]            gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t AF_LEVEL = ptr_t'(DEPTH - AF_MARGIN);

    ptr_t wbin;
    ptr_t wbin_next;
    ptr_t wgray_next;
    ptr_t rbin;
    ptr_t full_match;
    ptr_t fill;

    // Grants are blocked while full or in reset, so nothing is queued or half-written.
    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (~full & ~rst),
        .gnt     (gnt)
    );

    assign mem_we    = |gnt;
    assign mem_waddr = wbin[ADDR_WIDTH-1:0];
    assign mem_wdata = gnt[1] ? wdata1 : wdata0;

    // Next-pointer and status arithmetic, evaluated every cycle so full
    // clears as soon as the read side moves even when nobody writes.
    always_comb begin
        wbin_next  = wbin + ptr_t'(mem_we);
        wgray_next = ptr_t'(bin2gray(code_t'(wbin_next)));
        rbin       = ptr_t'(gray2bin(code_t'(rptr_gray_s)));
        // Full when write is exactly one lap ahead: Gray code of that differs
        // from the read pointer in its top two bits only.
        full_match = {~rptr_gray_s[ADDR_WIDTH:ADDR_WIDTH-1], rptr_gray_s[ADDR_WIDTH-2:0]};
        // Modular subtraction keeps the fill count correct across pointer wrap.
        fill       = wbin_next - rbin;
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= (wgray_next == full_match);
            almost_full <= (fill >= AF_LEVEL);
        end
    end

endmodule

// File: tb/tb_wr_port_arb.sv
// Self-checking bench for wr_port_arb: directed scenarios with random data
// and random request patterns, checked against a count-based FIFO model.
module tb_wr_port_arb;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int AFM   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [DW-1:0] wdata0 = '0;
    logic [DW-1:0] wdata1 = '0;
    logic [AW:0]   rptr_gray_s = '0;
    logic [1:0]    gnt;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW:0]   wptr_gray;
    logic          full;
    logic          almost_full;

    wr_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_MARGIN(AFM)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .rptr_gray_s (rptr_gray_s),
        .gnt         (gnt),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .wptr_gray   (wptr_gray),
        .full        (full),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Model: total writes and reads as plain counts; the fill level is their difference.
    int m_wcount = 0;
    int m_rcount = 0;
    int m_last   = 1;
    bit m_full   = 1'b0;
    bit m_af     = 1'b0;
    bit m_valid  = 1'b0;

    string       phase = "reset";
    logic [1:0]  last_gnt_obs;
    logic        last_we_obs;
    int          prev_waddr = -1;
    bit          saw_wrap = 1'b0;

    function automatic logic [AW:0] to_gray(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check 1 ns later, advance model at posedge.
    task automatic cycle(input bit r, input logic [1:0] q);
        logic [1:0]    exp_gnt;
        logic [DW-1:0] exp_data;
        int            fill;
        @(negedge clk);
        rst         = r;
        req         = q;
        wdata0      = DW'($urandom);
        wdata1      = DW'($urandom);
        rptr_gray_s = to_gray(m_rcount);
        #1;
        exp_gnt = 2'b00;
        if (!r && m_valid && !m_full) begin
            if (q == 2'b01)      exp_gnt = 2'b01;
            else if (q == 2'b10) exp_gnt = 2'b10;
            else if (q == 2'b11) exp_gnt = (m_last == 1) ? 2'b01 : 2'b10;
        end
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("mem_we", 32'(mem_we), 32'(|exp_gnt));
        last_gnt_obs = gnt;
        last_we_obs  = mem_we;
        if (exp_gnt != 2'b00) begin
            exp_data = exp_gnt[1] ? wdata1 : wdata0;
            check("mem_waddr", 32'(mem_waddr), 32'(m_wcount % DEPTH));
            check("mem_wdata", 32'(mem_wdata), 32'(exp_data));
            if (prev_waddr == DEPTH - 1 && mem_waddr == '0) saw_wrap = 1'b1;
            prev_waddr = int'(mem_waddr);
        end
        if (m_valid) begin
            check("wptr_gray", 32'(wptr_gray), 32'(to_gray(m_wcount)));
            check("full", 32'(full), 32'(m_full));
            check("almost_full", 32'(almost_full), 32'(m_af));
        end
        @(posedge clk);
        if (r) begin
            m_wcount = 0;
            m_last   = 1;
            m_full   = 1'b0;
            m_af     = 1'b0;
            m_valid  = 1'b1;
        end else begin
            if (exp_gnt != 2'b00) begin
                m_wcount++;
                m_last = exp_gnt[1] ? 1 : 0;
            end
            fill   = m_wcount - m_rcount;
            m_full = (fill == DEPTH);
            m_af   = (fill >= DEPTH - AFM);
        end
    endtask

    logic [1:0] tie_seq [4];

    initial begin
        tie_seq[0] = 2'b01;
        tie_seq[1] = 2'b10;
        tie_seq[2] = 2'b01;
        tie_seq[3] = 2'b10;

        // Reset with both requesting: no grant may appear.
        cycle(1'b1, 2'b11);
        cycle(1'b1, 2'b11);

        // Single requester 0 for three writes.
        phase = "single_req0";
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b01);
        #1;
        check("wptr_after_3", 32'(wptr_gray), 32'(7'b0000010));

        // Both requesting from reset: strict alternation starting with requester 0.
        phase = "tie_rr";
        cycle(1'b1, 2'b00);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'b11);
            check($sformatf("tie_gnt%0d", i), 32'(last_gnt_obs), 32'(tie_seq[i]));
        end

        // Fill to almost_full and then to full with random request patterns.
        phase = "fill";
        cycle(1'b1, 2'b00);
        for (int i = 0; i < 60; i++) cycle(1'b0, 2'($urandom_range(1, 3)));
        #1;
        check("af_after_60", 32'(almost_full), 32'(1));
        check("nfull_after_60", 32'(full), 32'(0));
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'($urandom_range(1, 3)));
        #1;
        check("full_after_64", 32'(full), 32'(1));
        cycle(1'b0, 2'b11);
        check("no_gnt_when_full", 32'(last_we_obs), 32'(0));
        cycle(1'b0, 2'b01);

        // One read frees one slot: one write, then full again.
        phase = "one_free";
        m_rcount = 1;
        cycle(1'b0, 2'b11);
        check("still_full_gnt", 32'(last_gnt_obs), 32'(0));
        #1;
        check("full_cleared", 32'(full), 32'(0));
        cycle(1'b0, 2'b11);
        check("one_write", 32'(last_we_obs), 32'(1));
        #1;
        check("full_again", 32'(full), 32'(1));
        cycle(1'b0, 2'b11);

        // Streaming with low fill across pointer wrap.
        phase = "wrap_stream";
        m_rcount = 0;
        cycle(1'b1, 2'b00);
        prev_waddr = -1;
        for (int k = 0; k < 2000 && m_wcount < 200; k++) begin
            logic [1:0] q;
            if (m_rcount < m_wcount && ($urandom_range(0, 1) == 1 || m_wcount - m_rcount >= 3))
                m_rcount++;
            q = (m_wcount - m_rcount >= 3) ? 2'b00 : 2'($urandom_range(0, 3));
            cycle(1'b0, q);
        end
        check("wrote_200", 32'(m_wcount >= 200), 32'(1));
        check("addr_wrapped", 32'(saw_wrap), 32'(1));

        // Reset in the middle of a stream of ties.
        phase = "mid_reset";
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'b11);
        m_rcount = 0;
        cycle(1'b1, 2'b11);
        check("rst_gnt", 32'(last_gnt_obs), 32'(0));
        #1;
        check("rst_wptr", 32'(wptr_gray), 32'(0));
        check("rst_full", 32'(full), 32'(0));
        cycle(1'b0, 2'b11);
        check("first_tie_after_rst", 32'(last_gnt_obs), 32'(2'b01));
        cycle(1'b0, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
